// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_pkg                                                       |
// | Description : Shared types, blanking constant and the hex glyph ROM for     |
// |               the multiplexed 7-segment scan driver.                         |
// | Contents    : seg7_t   - active-low segment word, bit order {g,f,e,d,c,b,a}  |
// |               nibble_t - one hex digit                                      |
// |               SEG7_OFF - all segments dark                                  |
// |               glyph()  - nibble to active-low segment pattern               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package seg7_pkg;

   typedef logic [6:0] seg7_t;
   typedef logic [3:0] nibble_t;

   localparam seg7_t SEG7_OFF = 7'h7F;

   // Active-low patterns; lowercase b and d keep them distinct from 8 and 0.
   function automatic seg7_t glyph(input nibble_t n);
      seg7_t s;
      case (n)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_glyph_decode                                              |
// | Description : Combinational hex nibble to active-low 7-segment decoder.     |
// | Ports       : nibble_i  in   4  hex digit value                              |
// |               seg_n_o   out  7  active-low segments {g,f,e,d,c,b,a}         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  nibble_t nibble_i,
   output seg7_t   seg_n_o
);

   assign seg_n_o = glyph(nibble_i);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_scan_driver                                               |
// | Description : Multiplexed N-digit 7-segment driver. A double-buffered digit |
// |               word is scanned over one shared active-low segment bus and    |
// |               NUM_DIGITS active-low anodes; each digit is lit REFRESH_DIV   |
// |               clocks. New data is only promoted at the frame wrap, so the   |
// |               display never shows a mix of old and new digits.              |
// | Ports       : clk        in   1             rising-edge clock              |
// |               rst_n      in   1             async active-low reset         |
// |               enable_i   in   1             0 = everything dark            |
// |               load_i     in   1             capture data_i/blank_i         |
// |               data_i     in   4*NUM_DIGITS  nibble k = digit k (0 right)   |
// |               blank_i    in   NUM_DIGITS    1 = digit k dark               |
// |               an_n_o     out  NUM_DIGITS    active-low one-hot anodes      |
// |               seg_n_o    out  7             active-low {g,f,e,d,c,b,a}     |
// |               frame_o    out  1             pulse after scan wraps to 0    |
// | Option      : SEG7_DP_EN adds dp_i (in, NUM_DIGITS) and dp_n_o (out, 1),    |
// |               decimal points buffered alongside data_i.                      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable_i,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] data_i,
   input  logic [NUM_DIGITS-1:0]   blank_i,
`ifdef SEG7_DP_EN
   input  logic [NUM_DIGITS-1:0]   dp_i,
`endif
   output logic [NUM_DIGITS-1:0]   an_n_o,
   output seg7_t                   seg_n_o,
   output logic                    frame_o
`ifdef SEG7_DP_EN
   ,
   output logic                    dp_n_o
`endif
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;

   logic [DIV_W-1:0]        pre_q,        pre_d;
   logic [IDX_W-1:0]        idx_q,        idx_d;
   logic [4*NUM_DIGITS-1:0] pend_data_q,  pend_data_d;
   logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic                    pend_vld_q,   pend_vld_d;
   logic [4*NUM_DIGITS-1:0] act_data_q,   act_data_d;
   logic [NUM_DIGITS-1:0]   act_blank_q,  act_blank_d;
   logic [NUM_DIGITS-1:0]   an_q,         an_d;
   seg7_t                   seg_q,        seg_d;
   logic                    frame_q,      frame_d;

   logic    w_tc;
   logic    w_wrap;
   nibble_t w_cur_nib;
   logic    w_cur_blank;
   seg7_t   w_glyph;

`ifdef SEG7_DP_EN
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0]   act_dp_q,  act_dp_d;
   logic                    dp_q,      dp_d;
   logic                    w_cur_dp;
`endif

   seg7_glyph_decode u_decode (
      .nibble_i (w_cur_nib),
      .seg_n_o  (w_glyph)
   );

   // Scan timing: prescaler and digit index run independently of enable_i so
   // the frame cadence never shifts when the display is switched off.
   always_comb begin
      w_tc   = (pre_q == DIV_W'(REFRESH_DIV - 1));
      w_wrap = w_tc && (idx_q == IDX_W'(NUM_DIGITS - 1));
      pre_d  = w_tc ? '0 : pre_q + DIV_W'(1);
      idx_d  = idx_q;
      if (w_tc) begin
         idx_d = w_wrap ? '0 : idx_q + IDX_W'(1);
      end
      frame_d = w_wrap;
   end

   // Double buffer. A load on the wrap cycle goes straight to the active
   // buffer so it is visible from this frame's digit 0; any older pending
   // word is superseded by it.
   always_comb begin
      pend_data_d  = pend_data_q;
      pend_blank_d = pend_blank_q;
      pend_vld_d   = pend_vld_q;
      act_data_d   = act_data_q;
      act_blank_d  = act_blank_q;
`ifdef SEG7_DP_EN
      pend_dp_d    = pend_dp_q;
      act_dp_d     = act_dp_q;
`endif
      if (w_wrap) begin
         pend_vld_d = 1'b0;
         if (load_i) begin
            act_data_d  = data_i;
            act_blank_d = blank_i;
`ifdef SEG7_DP_EN
            act_dp_d    = dp_i;
`endif
         end else if (pend_vld_q) begin
            act_data_d  = pend_data_q;
            act_blank_d = pend_blank_q;
`ifdef SEG7_DP_EN
            act_dp_d    = pend_dp_q;
`endif
         end
      end else if (load_i) begin
         pend_data_d  = data_i;
         pend_blank_d = blank_i;
         pend_vld_d   = 1'b1;
`ifdef SEG7_DP_EN
         pend_dp_d    = dp_i;
`endif
      end
   end

   // Output stage: registered from the current index, so the pins follow the
   // index one clock later and always pair a digit with its own anode.
   always_comb begin
      w_cur_nib   = '0;
      w_cur_blank = 1'b1;
`ifdef SEG7_DP_EN
      w_cur_dp    = 1'b0;
`endif
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            w_cur_nib   = act_data_q[4*k +: 4];
            w_cur_blank = act_blank_q[k];
`ifdef SEG7_DP_EN
            w_cur_dp    = act_dp_q[k];
`endif
         end
      end

      an_d  = '1;
      seg_d = SEG7_OFF;
`ifdef SEG7_DP_EN
      dp_d  = 1'b1;
`endif
      if (enable_i && !w_cur_blank) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
               an_d[k] = 1'b0;
            end
         end
         seg_d = w_glyph;
`ifdef SEG7_DP_EN
         dp_d  = ~w_cur_dp;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q        <= '0;
         idx_q        <= '0;
         pend_data_q  <= '0;
         pend_blank_q <= '0;
         pend_vld_q   <= 1'b0;
         act_data_q   <= '0;
         act_blank_q  <= '0;
         an_q         <= '1;
         seg_q        <= SEG7_OFF;
         frame_q      <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         idx_q        <= idx_d;
         pend_data_q  <= pend_data_d;
         pend_blank_q <= pend_blank_d;
         pend_vld_q   <= pend_vld_d;
         act_data_q   <= act_data_d;
         act_blank_q  <= act_blank_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_q      <= frame_d;
      end
   end

`ifdef SEG7_DP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_dp_q <= '0;
         act_dp_q  <= '0;
         dp_q      <= 1'b1;
      end else begin
         pend_dp_q <= pend_dp_d;
         act_dp_q  <= act_dp_d;
         dp_q      <= dp_d;
      end
   end

   assign dp_n_o = dp_q;
`endif

   assign an_n_o  = an_q;
   assign seg_n_o = seg_q;
   assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_scan_driver                                            |
// | Description : Directed self-checking bench for seg7_scan_driver with        |
// |               NUM_DIGITS=4, REFRESH_DIV=4 (16-clock frame).                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable_i;
   logic        load_i;
   logic [15:0] data_i;
   logic [3:0]  blank_i;
   logic [3:0]  an_n_o;
   logic [6:0]  seg_n_o;
   logic        frame_o;

   int total = 0;
   int bad   = 0;

   // Hand-written glyph table for 0..F, active-low {g..a}.
   logic [6:0] exp_glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_driver #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (enable_i),
      .load_i   (load_i),
      .data_i   (data_i),
      .blank_i  (blank_i),
      .an_n_o   (an_n_o),
      .seg_n_o  (seg_n_o),
      .frame_o  (frame_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance until frame_o is seen; returns number of clocks taken.
   task automatic wait_frame(input string tag, output int cycles);
      logic seen;
      seen   = 1'b0;
      cycles = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         cycles++;
         if (frame_o === 1'b1) seen = 1'b1;
      end
      total++;
      assert (seen) else begin
         bad++;
         $error("FAIL %s observed=timeout expected=frame_o", tag);
      end
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] b);
      data_i  = d;
      blank_i = b;
      load_i  = 1'b1;
      tick();
      load_i  = 1'b0;
      blank_i = 4'h0;
   endtask

   initial begin
      int  cyc;
      logic seen;
      rst_n    = 1'b0;
      enable_i = 1'b1;
      load_i   = 1'b0;
      data_i   = 16'h0;
      blank_i  = 4'h0;

      // 1: reset values, then digit 0 lit on the first edge after release
      tick(3);
      chk("rst_an", 16'(an_n_o), 16'hF);
      chk("rst_seg", 16'(seg_n_o), 16'h7F);
      chk("rst_frame", 16'(frame_o), 16'h0);
      rst_n = 1'b1;
      tick();
      chk("rel_an", 16'(an_n_o), 16'hE);
      chk("rel_seg", 16'(seg_n_o), 16'h40);

      // 2: 1234 scanned after the wrap, frame every 16 clocks
      load(16'h1234, 4'h0);
      wait_frame("t2_frame", cyc);
      tick();
      chk("t2_frame_low", 16'(frame_o), 16'h0);
      chk("t2_an0", 16'(an_n_o), 16'hE);
      chk("t2_seg0", 16'(seg_n_o), 16'h19);
      tick(4);
      chk("t2_an1", 16'(an_n_o), 16'hD);
      chk("t2_seg1", 16'(seg_n_o), 16'h30);
      tick(4);
      chk("t2_an2", 16'(an_n_o), 16'hB);
      chk("t2_seg2", 16'(seg_n_o), 16'h24);
      tick(4);
      chk("t2_an3", 16'(an_n_o), 16'h7);
      chk("t2_seg3", 16'(seg_n_o), 16'h79);
      tick(3);
      chk("t2_frame16", 16'(frame_o), 16'h1);

      // 3: every nibble through digit 0
      for (int v = 0; v < 16; v++) begin
         load(16'(v), 4'h0);
         wait_frame("t3_frame", cyc);
         tick();
         chk($sformatf("t3_glyph%0h", v), 16'(seg_n_o), 16'(exp_glyph[v]));
      end

      // 4: two loads inside one frame; old word stays until the wrap
      load(16'hABCD, 4'h0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (an_n_o === 4'hD) seen = 1'b1;
      end
      chk("t4_reach_d1", 16'(seen), 16'h1);
      chk("t4_no_tear", 16'(seg_n_o), 16'h40);
      load(16'h00EF, 4'h0);
      wait_frame("t4_frame", cyc);
      tick();
      chk("t4_seg0", 16'(seg_n_o), 16'h0E);
      tick(4);
      chk("t4_seg1", 16'(seg_n_o), 16'h06);
      tick(4);
      chk("t4_seg2", 16'(seg_n_o), 16'h40);
      tick(4);
      chk("t4_seg3", 16'(seg_n_o), 16'h40);

      // 5: load on the wrap cycle bypasses the pending buffer
      wait_frame("t5_sync", cyc);
      tick(15);
      data_i = 16'h5555;
      load_i = 1'b1;
      tick();
      load_i = 1'b0;
      chk("t5_wrap_frame", 16'(frame_o), 16'h1);
      tick();
      chk("t5_an0", 16'(an_n_o), 16'hE);
      chk("t5_seg0", 16'(seg_n_o), 16'h12);
      tick(4);
      chk("t5_seg1", 16'(seg_n_o), 16'h12);
      wait_frame("t5_next", cyc);
      tick();
      chk("t5_persist", 16'(seg_n_o), 16'h12);

      // 6: blanking, enable, mid-scan reset
      load(16'h1234, 4'b1000);
      wait_frame("t6_frame", cyc);
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk($sformatf("t6_an3_off_%0d", i), 16'(an_n_o[3]), 16'h1);
         if (i == 13) chk("t6_seg_blank", 16'(seg_n_o), 16'h7F);
         if (i == 9)  chk("t6_an2_on", 16'(an_n_o), 16'hB);
      end
      chk("t6_frame16", 16'(frame_o), 16'h1);
      enable_i = 1'b0;
      tick();
      chk("t6_dis_an", 16'(an_n_o), 16'hF);
      chk("t6_dis_seg", 16'(seg_n_o), 16'h7F);
      tick(15);
      chk("t6_dis_frame", 16'(frame_o), 16'h1);
      enable_i = 1'b1;
      tick();
      chk("t6_en_an", 16'(an_n_o), 16'hE);
      chk("t6_en_seg", 16'(seg_n_o), 16'h19);
      tick(5);
      rst_n = 1'b0;
      #1;
      chk("t6_arst_an", 16'(an_n_o), 16'hF);
      chk("t6_arst_seg", 16'(seg_n_o), 16'h7F);
      chk("t6_arst_frame", 16'(frame_o), 16'h0);
      tick();
      chk("t6_hold_an", 16'(an_n_o), 16'hF);
      rst_n = 1'b1;
      tick();
      chk("t6_rel_an", 16'(an_n_o), 16'hE);
      chk("t6_rel_seg", 16'(seg_n_o), 16'h40);
      wait_frame("t6_rel_frame", cyc);
      chk("t6_rel_period", 16'(cyc), 16'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
